turn_controller: RTL and testbench

- Game-sequencing stage directly upstream of the tic-tac-toe win-detect datapath.
- Accepts cell selections from the input/debounce logic and alternates turns between player 1 and player 2.
- Maintains the two 9-bit occupancy boards that feed the datapath `player1`/`player2` inputs, and samples the datapath's `p1win`/`p2win` after each move.
- Drives `done` back to the datapath and latches the final game result.

---
 rtl/turn_controller.sv | 163 ++++++++++++++++
 tb/tb_turn_controller.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - tic-tac-toe turn sequencer feeding the win-detect datapath
// Optional per-turn timeout enabled by defining TURN_TIMEOUT_EN.
module turn_controller #(
  parameter logic FIRST_PLAYER = 1'b0,
  parameter int   TURN_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] cell_idx,
  input  logic       p1win,
  input  logic       p2win,
  output logic [8:0] player1,
  output logic [8:0] player2,
  output logic       done,
  output logic       turn,
  output logic       move_ready,
  output logic       move_reject,
  output logic [1:0] result,
  output logic [3:0] move_count,
  output logic       timeout_pulse
);

  typedef enum logic [1:0] {IDLE, PLAY, CHECK, OVER} state_t;

  state_t      state, state_n;
  logic [8:0]  player1_n, player2_n;
  logic        turn_n;
  logic [3:0]  move_count_n;
  logic [1:0]  result_n;
  logic        move_reject_n;
  logic [15:0] occupied;
  logic [8:0]  cell_mask;
  logic        legal;

  // Zero-extended so out-of-range indices 9..15 read as free and fail the range test instead.
  assign occupied  = {7'b0, player1 | player2};
  assign cell_mask = 9'b1 << cell_idx;
  assign legal     = (cell_idx <= 4'd8) && !occupied[cell_idx];

`ifdef TURN_TIMEOUT_EN
  localparam int TW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;

  logic [TW-1:0] turn_timer, turn_timer_n;
  logic          timeout_pulse_n;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TURN_TIMEOUT;
  assign timeout_pulse      = 1'b0;
`endif

  always_comb begin
    state_n       = state;
    player1_n     = player1;
    player2_n     = player2;
    turn_n        = turn;
    move_count_n  = move_count;
    result_n      = result;
    move_reject_n = 1'b0;
`ifdef TURN_TIMEOUT_EN
    turn_timer_n    = turn_timer;
    timeout_pulse_n = 1'b0;
`endif

    case (state)
      PLAY: begin
        if (move_valid) begin
          if (legal) begin
            if (turn) player2_n = player2 | cell_mask;
            else      player1_n = player1 | cell_mask;
            move_count_n = (move_count == 4'd9) ? 4'd9 : move_count + 4'd1;
            state_n      = CHECK;
          end else begin
            move_reject_n = 1'b1;
          end
        end
`ifdef TURN_TIMEOUT_EN
        // An accepted move in the expiry cycle takes precedence over the timeout.
        if (move_valid && legal) begin
          turn_timer_n = '0;
        end else if (turn_timer == TW'(TURN_TIMEOUT - 1)) begin
          turn_n          = ~turn;
          timeout_pulse_n = 1'b1;
          turn_timer_n    = '0;
        end else begin
          turn_timer_n = turn_timer + 1'b1;
        end
`endif
      end
      CHECK: begin
        if (p1win) begin
          result_n = 2'b01;
          state_n  = OVER;
        end else if (p2win) begin
          result_n = 2'b10;
          state_n  = OVER;
        end else if (move_count == 4'd9) begin
          result_n = 2'b11;
          state_n  = OVER;
        end else begin
          turn_n  = ~turn;
          state_n = PLAY;
`ifdef TURN_TIMEOUT_EN
          turn_timer_n = '0;
`endif
        end
      end
      default: ;
    endcase

    if (new_game) begin
      state_n       = PLAY;
      player1_n     = '0;
      player2_n     = '0;
      turn_n        = FIRST_PLAYER;
      move_count_n  = '0;
      result_n      = 2'b00;
      move_reject_n = 1'b0;
`ifdef TURN_TIMEOUT_EN
      turn_timer_n    = '0;
      timeout_pulse_n = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      player1     <= '0;
      player2     <= '0;
      turn        <= FIRST_PLAYER;
      move_count  <= '0;
      result      <= 2'b00;
      move_reject <= 1'b0;
      done        <= 1'b0;
      move_ready  <= 1'b0;
    end else begin
      state       <= state_n;
      player1     <= player1_n;
      player2     <= player2_n;
      turn        <= turn_n;
      move_count  <= move_count_n;
      result      <= result_n;
      move_reject <= move_reject_n;
      done        <= (state_n == OVER);
      move_ready  <= (state_n == PLAY);
    end
  end

`ifdef TURN_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      turn_timer    <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      turn_timer    <= turn_timer_n;
      timeout_pulse <= timeout_pulse_n;
    end
  end
`endif

endmodule

// File: tb/tb_turn_controller.sv
// tb/tb_turn_controller.sv - scoreboard bench for turn_controller with a behavioural win-detect datapath
module tb_turn_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0;
  logic       move_valid = 1'b0;
  logic [3:0] cell_idx = 4'd0;
  logic       p1win, p2win;
  logic [8:0] player1, player2;
  logic       done, turn, move_ready, move_reject, timeout_pulse;
  logic [1:0] result;
  logic [3:0] move_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [8:0] p1;
    logic [8:0] p2;
    logic       turn;
    logic [3:0] cnt;
    logic [1:0] res;
    logic       done;
    logic       ready;
    logic       rej;
    logic       rej2;
  } snap_t;

  snap_t sb[$];
  snap_t obs[$];

  logic [8:0] m_p1, m_p2;
  logic       m_turn, m_play, m_over;
  logic [3:0] m_cnt;
  logic [1:0] m_res;

  turn_controller #(.FIRST_PLAYER(1'b0), .TURN_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid),
    .cell_idx(cell_idx), .p1win(p1win), .p2win(p2win), .player1(player1),
    .player2(player2), .done(done), .turn(turn), .move_ready(move_ready),
    .move_reject(move_reject), .result(result), .move_count(move_count),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic is_win(input logic [8:0] b);
    return ((b & 9'h007) == 9'h007) || ((b & 9'h038) == 9'h038) ||
           ((b & 9'h1C0) == 9'h1C0) || ((b & 9'h049) == 9'h049) ||
           ((b & 9'h092) == 9'h092) || ((b & 9'h124) == 9'h124) ||
           ((b & 9'h111) == 9'h111) || ((b & 9'h054) == 9'h054);
  endfunction

  // Datapath stand-in: flags follow the boards and are forced low while done is high.
  assign p1win = !done && is_win(player1);
  assign p2win = !done && is_win(player2);

  task automatic model_new_game();
    m_p1 = '0; m_p2 = '0; m_turn = 1'b0; m_cnt = '0; m_res = 2'b00;
    m_play = 1'b1; m_over = 1'b0;
  endtask

  task automatic start_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_new_game();
  endtask

  task automatic play(input logic [3:0] c);
    snap_t e, o;
    logic [15:0] occ;
    logic legal;
    occ   = {7'b0, m_p1 | m_p2};
    legal = m_play && (c <= 4'd8) && !occ[c];
    e.rej  = m_play && !legal;
    e.rej2 = 1'b0;
    if (legal) begin
      if (m_turn) m_p2[c] = 1'b1; else m_p1[c] = 1'b1;
      m_cnt = m_cnt + 4'd1;
      if (is_win(m_p1))      begin m_res = 2'b01; m_over = 1'b1; m_play = 1'b0; end
      else if (is_win(m_p2)) begin m_res = 2'b10; m_over = 1'b1; m_play = 1'b0; end
      else if (m_cnt == 9)   begin m_res = 2'b11; m_over = 1'b1; m_play = 1'b0; end
      else m_turn = ~m_turn;
    end
    e.p1 = m_p1; e.p2 = m_p2; e.turn = m_turn; e.cnt = m_cnt; e.res = m_res;
    e.done = m_over; e.ready = m_play;
    sb.push_back(e);
    @(negedge clk);
    cell_idx   = c;
    move_valid = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    o.rej = move_reject;
    @(negedge clk);
    o.rej2 = move_reject;
    o.p1 = player1; o.p2 = player2; o.turn = turn; o.cnt = move_count; o.res = result;
    o.done = done; o.ready = move_ready;
    obs.push_back(o);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({player1, player2, move_count, result} !== 24'h0) begin
      errors++;
      $display("FAIL reset_regs: got %h expected 0", {player1, player2, move_count, result});
    end
    checks++;
    if ({turn, done, move_ready, move_reject, timeout_pulse} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {turn, done, move_ready, move_reject, timeout_pulse});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_new_game();
    start_game();
    checks++;
    if ({move_ready, turn, done, player1, player2, move_count} !== {3'b100, 22'h0}) begin
      errors++;
      $display("FAIL new_game: got ready=%b turn=%b done=%b p1=%h p2=%h cnt=%0d expected ready=1 rest 0",
               move_ready, turn, done, player1, player2, move_count);
    end
  endtask

  task automatic test_p1_win();
    snap_t e, o;
    start_game();
    play(4'd0); play(4'd3); play(4'd1); play(4'd4); play(4'd2);
    play(4'd6);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL p1_win move %0d: got %h expected %h", i, o, e);
      end
    end
    checks++;
    if ({player1, result, done, move_count} !== {9'h007, 2'b01, 1'b1, 4'd5}) begin
      errors++;
      $display("FAIL p1_win_final: got p1=%h res=%b done=%b cnt=%0d expected p1=007 res=01 done=1 cnt=5",
               player1, result, done, move_count);
    end
  endtask

  task automatic test_p2_win();
    snap_t e, o;
    start_game();
    play(4'd0); play(4'd3); play(4'd1); play(4'd4); play(4'd8); play(4'd5);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL p2_win move %0d: got %h expected %h", i, o, e);
      end
    end
    checks++;
    if ({player2, result} !== {9'h038, 2'b10}) begin
      errors++;
      $display("FAIL p2_win_final: got p2=%h res=%b expected p2=038 res=10", player2, result);
    end
  endtask

  task automatic test_reject();
    snap_t e, o;
    start_game();
    play(4'd4); play(4'd4); play(4'd12);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reject move %0d: got %h expected %h", i, o, e);
      end
    end
    checks++;
    if ({turn, player1, player2, move_count} !== {1'b1, 9'h010, 9'h000, 4'd1}) begin
      errors++;
      $display("FAIL reject_final: got turn=%b p1=%h p2=%h cnt=%0d expected turn=1 p1=010 p2=000 cnt=1",
               turn, player1, player2, move_count);
    end
  endtask

  task automatic test_draw();
    snap_t e, o;
    start_game();
    play(4'd0); play(4'd1); play(4'd2); play(4'd4); play(4'd3);
    play(4'd5); play(4'd7); play(4'd6); play(4'd8);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL draw move %0d: got %h expected %h", i, o, e);
      end
    end
    checks++;
    if ({result, move_count, player1, player2} !== {2'b11, 4'd9, 9'h18D, 9'h072}) begin
      errors++;
      $display("FAIL draw_final: got res=%b cnt=%0d p1=%h p2=%h expected res=11 cnt=9 p1=18d p2=072",
               result, move_count, player1, player2);
    end
  endtask

  task automatic test_win_on_ninth();
    snap_t e, o;
    start_game();
    play(4'd1); play(4'd2); play(4'd5); play(4'd3); play(4'd0);
    play(4'd6); play(4'd4); play(4'd7); play(4'd8);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL ninth_win move %0d: got %h expected %h", i, o, e);
      end
    end
    checks++;
    if ({result, move_count, player1} !== {2'b01, 4'd9, 9'h133}) begin
      errors++;
      $display("FAIL ninth_win_final: got res=%b cnt=%0d p1=%h expected res=01 cnt=9 p1=133",
               result, move_count, player1);
    end
  endtask

  task automatic test_new_game_priority();
    snap_t e, o;
    start_game();
    play(4'd0);
    e = sb.pop_front(); o = obs.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL priority_setup: got %h expected %h", o, e);
    end
    @(negedge clk);
    new_game = 1'b1; move_valid = 1'b1; cell_idx = 4'd5;
    @(negedge clk);
    new_game = 1'b0; move_valid = 1'b0;
    model_new_game();
    checks++;
    if ({player1, player2, turn, move_count, move_reject, move_ready} !== {24'h0, 1'b1}) begin
      errors++;
      $display("FAIL new_game_priority: got p1=%h p2=%h turn=%b cnt=%0d rej=%b ready=%b expected boards 0 turn 0 cnt 0 rej 0 ready 1",
               player1, player2, turn, move_count, move_reject, move_ready);
    end
  endtask

  task automatic test_reset_midgame();
    snap_t e, o;
    start_game();
    play(4'd4); play(4'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL midgame_setup: got %h expected %h", o, e);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({player1, player2, move_count, result, turn, done, move_ready, move_reject} !== 28'h0) begin
      errors++;
      $display("FAIL reset_midgame: got p1=%h p2=%h cnt=%0d res=%b turn=%b done=%b ready=%b expected all 0",
               player1, player2, move_count, result, turn, done, move_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef TURN_TIMEOUT_EN
  task automatic test_timeout();
    snap_t e, o;
    int pulse_at;
    start_game();
    pulse_at = -1;
    for (int k = 1; k <= 20 && pulse_at < 0; k++) begin
      @(negedge clk);
      if (timeout_pulse === 1'b1) pulse_at = k;
    end
    checks++;
    if (pulse_at != 8 || turn !== 1'b1) begin
      errors++;
      $display("FAIL timeout_first: got cycle=%0d turn=%b expected cycle=8 turn=1", pulse_at, turn);
    end
    @(negedge clk);
    checks++;
    if (timeout_pulse !== 1'b0 || move_count !== 4'd0) begin
      errors++;
      $display("FAIL timeout_width: got pulse=%b cnt=%0d expected pulse=0 cnt=0", timeout_pulse, move_count);
    end
    start_game();
    play(4'd4);
    e = sb.pop_front(); o = obs.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL timeout_move: got %h expected %h", o, e);
    end
    repeat (3) @(negedge clk);
    start_game();
    checks++;
    if ({player1, player2, turn} !== 19'h0) begin
      errors++;
      $display("FAIL timeout_new_game: got p1=%h p2=%h turn=%b expected 0", player1, player2, turn);
    end
    pulse_at = -1;
    for (int k = 1; k <= 20 && pulse_at < 0; k++) begin
      @(negedge clk);
      if (timeout_pulse === 1'b1) pulse_at = k;
    end
    checks++;
    if (pulse_at != 8) begin
      errors++;
      $display("FAIL timeout_restart: got cycle=%0d expected cycle=8", pulse_at);
    end
  endtask
`else
  task automatic test_timeout();
    int highs;
    start_game();
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (timeout_pulse !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0 || turn !== 1'b0) begin
      errors++;
      $display("FAIL timeout_disabled: got pulses=%0d turn=%b expected pulses=0 turn=0", highs, turn);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_new_game();
    test_p1_win();
    test_p2_win();
    test_reject();
    test_draw();
    test_win_on_ninth();
    test_new_game_priority();
    test_reset_midgame();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
